cla_pipelined: RTL and testbench
================================

CLA_PIPELINED -- requirements
Module: cla_pipelined

Interface
REQ-001 SHALL have parameter ADDER_WIDTH, default 32, total operand/sum width in bits.
REQ-002 SHALL have parameter BLOCK_WIDTH, default 8, bits resolved per pipeline stage by a carry-lookahead block.
REQ-003 SHALL derive NUM_STAGES = ADDER_WIDTH/BLOCK_WIDTH; ADDER_WIDTH not a multiple of BLOCK_WIDTH, or BLOCK_WIDTH < 1, SHALL be an elaboration error.
REQ-004 iClk  input  1  sole clock; all state updates on rising edge.
REQ-005 iRst  input  1  reset, synchronous, active-high.
REQ-006 iA  input  ADDER_WIDTH  operand A.
REQ-007 iB  input  ADDER_WIDTH  operand B.
REQ-008 iCarry  input  1  carry-in (add) / borrow-in (subtract).
REQ-009 iSub  input  1  mode: 0 = add, 1 = subtract.
REQ-010 iValid  input  1  upstream offers an operation this cycle.
REQ-011 oReady  output  1  block accepts an operation this cycle.
REQ-012 oSum  output  ADDER_WIDTH  result.
REQ-013 oCarry  output  1  carry-out of MSB (subtract: 1 = no borrow).
REQ-014 oOverflow  output  1  two's-complement signed overflow.
REQ-015 oValid  output  1  oSum/oCarry/oOverflow hold a valid result.
REQ-016 iReady  input  1  downstream accepts the result this cycle.

Function
REQ-017 SHALL compute effective B' = iB XOR {ADDER_WIDTH{iSub}} and cin' = iCarry XOR iSub, giving A+B+cin (add) and A-B-iCarry (subtract).
REQ-018 SHALL accept an operation on a rising edge when iValid=1 and oReady=1; otherwise inputs SHALL be ignored.
REQ-019 Stage k (0..NUM_STAGES-1) SHALL compute bits [k*BLOCK_WIDTH +: BLOCK_WIDTH] with a BLOCK_WIDTH-bit carry-lookahead (g=a&b, p=a^b, c[i+1]=g[i]|p[i]&c[i]), carry-in from the registered carry of stage k-1 (stage 0: cin').
REQ-020 Unprocessed upper operand slices SHALL be skewed forward through per-stage registers; completed lower sum slices SHALL be delayed so all oSum bits belong to the same operation.
REQ-021 Pipeline SHALL advance as a whole when adv = (~oValid | iReady); oReady SHALL equal adv (combinational).
REQ-022 Latency SHALL be exactly NUM_STAGES cycles from acceptance to oValid=1 with no stall; throughput one operation per cycle.
REQ-023 Each stage SHALL carry a valid bit; bubbles (iValid=0 on an advance) SHALL propagate as invalid slots and SHALL NOT be collapsed.
REQ-024 When adv=0 all stage registers, oSum, oCarry, oOverflow, oValid SHALL hold unchanged.
REQ-025 A result SHALL be consumed on a rising edge with oValid=1 and iReady=1; each accepted operation SHALL produce exactly one result, in order.
REQ-026 oOverflow SHALL equal carry into MSB XOR carry out of MSB of the final stage.
REQ-027 oSum/oCarry/oOverflow when oValid=0 SHALL be don't-care for checking but SHALL be registered outputs (no combinational input-to-output path except oReady).
REQ-028 NUM_STAGES=1 SHALL degenerate to a single registered CLA with latency 1.

Reset
REQ-029 iRst=1 at a rising edge SHALL clear all stage valid bits, oValid, oSum, oCarry, oOverflow to 0; oReady SHALL then read 1.
REQ-030 iRst SHALL take priority over acceptance and advance; operations in flight SHALL be discarded, not emitted.
REQ-031 An operation with iValid=1 on the same edge as iRst=1 SHALL NOT be accepted.

Verification (ADDER_WIDTH=32, BLOCK_WIDTH=8, latency 4)
REQ-032 Reset: iRst=1 two cycles -> oValid=0, oSum=0x00000000, oCarry=0, oOverflow=0, oReady=1.
REQ-033 Full-width carry ripple: A=0xFFFFFFFF, B=0x00000001, iCarry=0, iSub=0, accepted cycle T -> cycle T+4 oValid=1, oSum=0x00000000, oCarry=1, oOverflow=0.
REQ-034 Subtract overflow: A=0x80000000, B=0x00000001, iSub=1, iCarry=0 -> oSum=0x7FFFFFFF, oCarry=1, oOverflow=1.
REQ-035 Throughput: four back-to-back operations (1+2, 3+4, 0x7FFFFFFF+1, 0xFFFFFFFF+0 cin=1) with iReady=1 -> results 3, 7, 0x80000000 (oOverflow=1), 0x00000000 (oCarry=1) on cycles T+4..T+7 in order.
REQ-036 Backpressure: pipeline full, iReady=0 for 3 cycles -> oReady=0, outputs frozen; iReady=1 -> remaining results emerge in order, none lost or duplicated.
REQ-037 Reset mid-operation: two operations in flight, iRst=1 one cycle -> oValid stays 0 for following 4 cycles with iValid=0; new operation afterwards returns correct result at latency 4.

Source files
------------

// File: rtl/cla_pipelined_if.sv
// Operand/result bundle for the pipelined carry-lookahead adder.
// Names keep the adder's point of view: i* flow into the adder, o* flow out of it.
interface cla_pipelined_if #(
    parameter int ADDER_WIDTH = 32
);
    logic [ADDER_WIDTH-1:0] iA;
    logic [ADDER_WIDTH-1:0] iB;
    logic                   iCarry;
    logic                   iSub;
    logic                   iValid;
    logic                   oReady;
    logic [ADDER_WIDTH-1:0] oSum;
    logic                   oCarry;
    logic                   oOverflow;
    logic                   oValid;
    logic                   iReady;

    modport slave (
        input  iA, iB, iCarry, iSub, iValid, iReady,
        output oReady, oSum, oCarry, oOverflow, oValid
    );

    modport master (
        output iA, iB, iCarry, iSub, iValid, iReady,
        input  oReady, oSum, oCarry, oOverflow, oValid
    );
endinterface

// File: rtl/cla_pipelined.sv
// Pipelined add/subtract: one BLOCK_WIDTH-bit carry-lookahead slice per stage,
// upper operand slices skewed forward, finished sum slices carried along.
module cla_pipelined #(
    parameter int ADDER_WIDTH = 32,
    parameter int BLOCK_WIDTH = 8
) (
    input logic            iClk,
    input logic            iRst,
    cla_pipelined_if.slave bus
);
    localparam int BW_SAFE    = (BLOCK_WIDTH > 0) ? BLOCK_WIDTH : 1;
    localparam int NUM_STAGES = ADDER_WIDTH / BW_SAFE;

    if (BLOCK_WIDTH < 1 || (ADDER_WIDTH % BW_SAFE) != 0 || NUM_STAGES < 1) begin : g_bad_params
        $error("cla_pipelined: ADDER_WIDTH must be a positive multiple of BLOCK_WIDTH >= 1");
    end

    logic                   v_q [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] a_q [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] b_q [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] s_q [NUM_STAGES];
    logic                   c_q [NUM_STAGES];
    logic                   ov_q;

    logic                   v_d [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] a_d [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] b_d [NUM_STAGES];
    logic [ADDER_WIDTH-1:0] s_d [NUM_STAGES];
    logic                   c_d [NUM_STAGES];
    logic                   ov_d;

    logic                   adv;

    // Handshake: an operation is taken on a rising edge with iValid && oReady,
    // a result leaves on a rising edge with oValid && iReady. The whole pipe
    // moves together whenever the output slot is empty or being drained.
    assign adv        = ~v_q[NUM_STAGES-1] | bus.iReady;
    assign bus.oReady = adv;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        logic [ADDER_WIDTH-1:0] in_a;
        logic [ADDER_WIDTH-1:0] in_b;
        logic [ADDER_WIDTH-1:0] in_s;
        logic                   in_c;
        logic                   in_v;
        logic [BW_SAFE-1:0]     blk_a;
        logic [BW_SAFE-1:0]     blk_b;
        logic [BW_SAFE-1:0]     blk_g;
        logic [BW_SAFE-1:0]     blk_p;
        logic [BW_SAFE:0]       blk_c;

        if (k == 0) begin : g_head
            // Subtraction folds into addition of the inverted operand.
            assign in_a = bus.iA;
            assign in_b = bus.iB ^ {ADDER_WIDTH{bus.iSub}};
            assign in_c = bus.iCarry ^ bus.iSub;
            assign in_s = '0;
            assign in_v = bus.iValid;
        end else begin : g_body
            assign in_a = a_q[k-1];
            assign in_b = b_q[k-1];
            assign in_c = c_q[k-1];
            assign in_s = s_q[k-1];
            assign in_v = v_q[k-1];
        end

        assign blk_a = BW_SAFE'(in_a >> (k * BW_SAFE));
        assign blk_b = BW_SAFE'(in_b >> (k * BW_SAFE));
        assign blk_g = blk_a & blk_b;
        assign blk_p = blk_a ^ blk_b;

        always_comb begin
            blk_c[0] = in_c;
            for (int i = 0; i < BW_SAFE; i++) begin
                blk_c[i+1] = blk_g[i] | (blk_p[i] & blk_c[i]);
            end
        end

        assign v_d[k] = in_v;
        assign a_d[k] = in_a;
        assign b_d[k] = in_b;
        assign c_d[k] = blk_c[BW_SAFE];
        assign s_d[k] = in_s | (ADDER_WIDTH'(blk_p ^ blk_c[BW_SAFE-1:0]) << (k * BW_SAFE));

        if (k == NUM_STAGES - 1) begin : g_tail
            assign ov_d = blk_c[BW_SAFE] ^ blk_c[BW_SAFE-1];
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
            ov_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
            ov_q <= ov_d;
        end
    end

    assign bus.oValid    = v_q[NUM_STAGES-1];
    assign bus.oSum      = s_q[NUM_STAGES-1];
    assign bus.oCarry    = c_q[NUM_STAGES-1];
    assign bus.oOverflow = ov_q;
endmodule

// File: tb/tb_cla_pipelined.sv
// Directed and randomized checks of cla_pipelined (32-bit, 8-bit blocks, latency 4)
// against an arithmetic reference model and an in-order expected queue.
module tb_cla_pipelined;
    localparam int W = 32;
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -64'sh8000_0000;

    logic iClk;
    logic iRst;

    cla_pipelined_if #(.ADDER_WIDTH(W)) bus ();

    cla_pipelined #(.ADDER_WIDTH(W), .BLOCK_WIDTH(8)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    int checks   = 0;
    int errors   = 0;
    int accepted = 0;
    int consumed = 0;
    int dropped  = 0;

    logic [33:0] exp_q[$];
    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE};

    // ---------------- clock / reset ----------------
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Result packed as {overflow, carry, sum}; carry on subtract means no borrow.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
        longint ua, ub, sa, sb, ci, u, r;
        logic   carry;
        logic   ovf;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ci = longint'({63'b0, cin});
        if (!sub) begin
            u     = ua + ub + ci;
            carry = (u > 64'sh0_FFFF_FFFF);
            r     = sa + sb + ci;
        end else begin
            u     = ua - ub - ci;
            carry = (ua >= ub + ci);
            r     = sa - sb - ci;
        end
        ovf = (r > SMAX) || (r < SMIN);
        return {ovf, carry, u[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge iClk) begin
        logic [33:0] exp;
        if (iRst) begin
            dropped += exp_q.size();
            exp_q.delete();
        end else begin
            if (bus.oValid && bus.iReady) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $error("FAIL unexpected_result observed=%h expected=none",
                           {bus.oOverflow, bus.oCarry, bus.oSum});
                end else begin
                    exp = exp_q.pop_front();
                    consumed++;
                    assert ({bus.oOverflow, bus.oCarry, bus.oSum} === exp) else begin
                        errors++;
                        $error("FAIL result observed=%h expected=%h",
                               {bus.oOverflow, bus.oCarry, bus.oSum}, exp);
                    end
                end
            end
            if (bus.iValid && bus.oReady) begin
                exp_q.push_back(model(bus.iA, bus.iB, bus.iCarry, bus.iSub));
                accepted++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        bus.iA     = a;
        bus.iB     = b;
        bus.iCarry = cin;
        bus.iSub   = sub;
        bus.iValid = 1'b1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] result();
        return 64'({bus.oOverflow, bus.oCarry, bus.oSum});
    endfunction

    task automatic single_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic sub, input logic [33:0] exp);
        bus.iReady = 1'b1;
        drive(a, b, cin, sub);
        tick();
        bus.iValid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check({tag, "_early"}, 64'(bus.oValid), 64'd0);
            tick();
        end
        check({tag, "_valid"}, 64'(bus.oValid), 64'd1);
        check({tag, "_result"}, result(), 64'(exp));
        tick();
    endtask

    task automatic drain(input string tag);
        bus.iValid = 1'b0;
        bus.iReady = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        tick();
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_idle"}, 64'(bus.oValid), 64'd0);
        check({tag, "_count"}, 64'(consumed), 64'(accepted - dropped));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] bp_a [5];
        logic [31:0] bp_b [5];
        logic        bp_c [5];
        logic        bp_s [5];
        logic [31:0] ra, rb;
        logic        rc, rs;

        // Reset held two cycles with an operation offered on the same edges.
        iRst       = 1'b1;
        bus.iA     = 32'h1234_5678;
        bus.iB     = 32'h1111_1111;
        bus.iCarry = 1'b1;
        bus.iSub   = 1'b0;
        bus.iValid = 1'b1;
        bus.iReady = 1'b1;
        tick();
        tick();
        check("rst_valid", 64'(bus.oValid), 64'd0);
        check("rst_sum", 64'(bus.oSum), 64'd0);
        check("rst_carry", 64'(bus.oCarry), 64'd0);
        check("rst_ovf", 64'(bus.oOverflow), 64'd0);
        check("rst_ready", 64'(bus.oReady), 64'd1);
        iRst       = 1'b0;
        bus.iValid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("rst_not_accepted", 64'(bus.oValid), 64'd0);
            tick();
        end

        single_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 34'h1_0000_0000);
        single_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 34'h3_7FFF_FFFF);
        single_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 34'h0_FFFF_FFFD);

        // Four back-to-back operations, results on consecutive cycles.
        bus.iReady = 1'b1;
        drive(32'd1, 32'd2, 1'b0, 1'b0);                 tick();
        drive(32'd3, 32'd4, 1'b0, 1'b0);                 tick();
        drive(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);         tick();
        drive(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);         tick();
        bus.iValid = 1'b0;
        check("tput0_valid", 64'(bus.oValid), 64'd1);
        check("tput0", result(), 64'h0_0000_0003);
        tick();
        check("tput1_valid", 64'(bus.oValid), 64'd1);
        check("tput1", result(), 64'h0_0000_0007);
        tick();
        check("tput2_valid", 64'(bus.oValid), 64'd1);
        check("tput2", result(), 64'h2_8000_0000);
        tick();
        check("tput3_valid", 64'(bus.oValid), 64'd1);
        check("tput3", result(), 64'h1_0000_0000);
        tick();
        drain("tput");

        // Backpressure with a full pipe and a pending offer.
        for (int i = 0; i < 5; i++) begin
            bp_a[i] = pick();
            bp_b[i] = pick();
            bp_c[i] = 1'($urandom_range(0, 1));
            bp_s[i] = 1'($urandom_range(0, 1));
        end
        bus.iReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(bp_a[i], bp_b[i], bp_c[i], bp_s[i]);
            tick();
        end
        bus.iReady = 1'b0;
        drive(bp_a[4], bp_b[4], bp_c[4], bp_s[4]);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_ready", 64'(bus.oReady), 64'd0);
            check("bp_valid", 64'(bus.oValid), 64'd1);
            check("bp_hold", result(), 64'(model(bp_a[0], bp_b[0], bp_c[0], bp_s[0])));
            tick();
        end
        bus.iReady = 1'b1;
        tick();
        drain("bp");

        // Reset with two operations in flight.
        bus.iReady = 1'b1;
        drive(pick(), pick(), 1'b0, 1'b0); tick();
        drive(pick(), pick(), 1'b1, 1'b1); tick();
        bus.iValid = 1'b0;
        iRst       = 1'b1;
        tick();
        iRst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("midrst_flush", 64'(bus.oValid), 64'd0);
            tick();
        end
        ra = pick();
        rb = pick();
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        single_op("post_rst", ra, rb, rc, rs, model(ra, rb, rc, rs));
        drain("midrst");

        // Random traffic with bubbles and random backpressure.
        for (int n = 0; n < 300; n++) begin
            drive(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            bus.iValid = ($urandom_range(0, 3) != 0);
            bus.iReady = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
